// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and default frame/oversample constants.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_DATA_BITS  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_rx_state_e;

endpackage

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the line's idle level.
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic CLKIN,
    input  logic RESET,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit qualification at mid-bit, LSB-first data, stop-bit check.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
    parameter int unsigned DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 CLKIN,
    input  logic                 RESET,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

    logic rx_s;

    uart_rx_state_e        state_q,     state_d;
    logic [TICK_W-1:0]     tick_cnt_q,  tick_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q,   bit_cnt_d;
    logic [DATA_BITS-1:0]  shift_q,     shift_d;
    logic [DATA_BITS-1:0]  data_q,      data_d;
    logic                  valid_q,     valid_d;
    logic                  frame_err_q, frame_err_d;

    sync2 #(.RESET_VAL(1'b1)) u_sync (
        .CLKIN (CLKIN),
        .RESET (RESET),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge CLKIN or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Pulses default low every cycle so they last one CLKIN cycle even between ticks.
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;

        if (baud_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d    = ST_START;
                        tick_cnt_d = '0;
                    end
                end
                ST_START: begin
                    if (tick_cnt_q == HALF_LAST) begin
                        if (rx_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d    = ST_DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_cnt_q == FULL_LAST) begin
                        shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                ST_STOP: begin
                    if (tick_cnt_q == FULL_LAST) begin
                        if (rx_s) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                        state_d    = ST_IDLE;
                        tick_cnt_d = '0;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are scheduled in baud-tick time and a tick-indexed model predicts every output.
module tb_uart_rx;

    localparam int OS     = 16;
    localparam int DB     = 8;
    localparam int T_HALF = OS / 2;                // ticks from start detection to start sample
    localparam int T_STOP = 1 + T_HALF + OS * (DB + 1); // frame-relative tick of stop sample

    logic       CLKIN     = 1'b0;
    logic       RESET     = 1'b0;
    logic       baud_tick = 1'b0;
    logic       rx        = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
        .CLKIN     (CLKIN),
        .RESET     (RESET),
        .baud_tick (baud_tick),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 CLKIN = ~CLKIN;

    typedef struct {
        int         tick;
        bit         good;
        logic [7:0] b;
    } ev_t;

    ev_t        exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] model_data = 8'h00;
    int         win_lo = 0;
    int         win_hi = 0;
    int         tick_num = 0;
    int         cur_id = 0;
    bit         tick_en = 1'b1;
    int         valid_seen = 0;
    int         fe_seen = 0;

    // Baud strobe: one cycle in every 25, numbered so frames can be scheduled by tick id.
    initial begin
        int cyc;
        cyc = 0;
        forever begin
            @(posedge CLKIN);
            #1;
            cyc++;
            if (tick_en && (cyc % 25 == 0)) begin
                tick_num++;
                baud_tick = 1'b1;
            end else begin
                baud_tick = 1'b0;
            end
        end
    end

    // Per-cycle compare against the tick-indexed model.
    initial begin
        bit         prev_tick;
        int         prev_id;
        int         after;
        int         last_tick;
        bit         exp_v;
        bit         exp_fe;
        bit         exp_busy;
        ev_t        ev;
        prev_tick = 1'b0;
        prev_id   = 0;
        last_tick = -1;
        forever begin
            @(negedge CLKIN);
            after     = prev_tick ? prev_id : -1;
            prev_tick = baud_tick;
            prev_id   = tick_num;
            if (after >= 0) last_tick = after;
            if (valid) valid_seen++;
            if (frame_err) fe_seen++;
            if (RESET) begin
                n_cmp++;
                if (data !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL reset_outputs t=%0t got data=%h v=%b fe=%b busy=%b, required all zero",
                             $time, data, valid, frame_err, busy);
                end
            end else begin
                exp_v  = 1'b0;
                exp_fe = 1'b0;
                if (exp_q.size() > 0 && after >= 0 && exp_q[0].tick == after) begin
                    ev = exp_q.pop_front();
                    if (ev.good) begin
                        exp_v      = 1'b1;
                        model_data = ev.b;
                    end else begin
                        exp_fe = 1'b1;
                    end
                end
                exp_busy = (last_tick >= win_lo) && (last_tick < win_hi);
                n_cmp++;
                if (valid !== exp_v || frame_err !== exp_fe || data !== model_data || busy !== exp_busy) begin
                    n_bad++;
                    $display("FAIL cycle_check t=%0t tick=%0d got v=%b fe=%b data=%h busy=%b, required v=%b fe=%b data=%h busy=%b",
                             $time, last_tick, valid, frame_err, data, busy, exp_v, exp_fe, model_data, exp_busy);
                end
            end
        end
    end

    initial begin
        #990000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, got, req);
        end
    endtask

    task automatic wait_tick();
        @(posedge CLKIN iff baud_tick);
        cur_id = tick_num;
        #2;
    endtask

    // Drives one frame starting right after the current tick; abort_at >= 0 stops mid-bit.
    task automatic send_frame(input logic [7:0] byte_v, input bit stop, input int abort_at);
        int         t0;
        logic [9:0] bits;
        t0   = cur_id;
        bits = {stop, byte_v, 1'b0};
        win_lo = t0 + 1;
        win_hi = t0 + T_STOP;
        if (abort_at < 0) exp_q.push_back('{tick: t0 + T_STOP, good: stop, b: byte_v});
        for (int i = 0; i < 10; i++) begin
            rx = bits[i];
            if (i == abort_at) begin
                repeat (OS / 2) wait_tick();
                return;
            end
            if (i == 9 && !stop) begin
                // Low stop bit released right after its sample so the line idles before the next frame.
                repeat (T_HALF + 1) wait_tick();
                rx = 1'b1;
                repeat (OS - T_HALF - 1) wait_tick();
            end else begin
                repeat (OS) wait_tick();
            end
        end
    endtask

    task automatic glitch(input int low_ticks);
        int t0;
        t0     = cur_id;
        win_lo = t0 + 1;
        win_hi = t0 + 1 + T_HALF;
        rx     = 1'b0;
        repeat (low_ticks) wait_tick();
        rx = 1'b1;
        repeat (OS) wait_tick();
    endtask

    initial begin
        int         v0;
        int         gap;
        logic [7:0] rb;
        bit         rs;

        #1 RESET = 1'b1;
        repeat (4) @(posedge CLKIN);
        #2;
        chk("reset_data", 32'(data), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        RESET = 1'b0;
        wait_tick();
        wait_tick();

        send_frame(8'hA5, 1'b1, -1);
        repeat (2) wait_tick();
        chk("a5_data", 32'(data), 32'hA5);
        chk("a5_model", 32'(model_data), 32'hA5);
        chk("a5_valid_count", 32'(valid_seen), 32'd1);
        chk("a5_busy_after", 32'(busy), 32'h0);

        glitch(4);
        chk("glitch_busy", 32'(busy), 32'h0);
        chk("glitch_valid_count", 32'(valid_seen), 32'd1);
        chk("glitch_fe_count", 32'(fe_seen), 32'd0);

        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h3C, 1'b0, -1);
        repeat (2) wait_tick();
        chk("ferr_count", 32'(fe_seen), 32'd1);
        chk("ferr_data_kept", 32'(data), 32'h11);

        v0 = valid_seen;
        send_frame(8'hC3, 1'b1, 4);
        RESET = 1'b1;
        #1;
        chk("abort_data", 32'(data), 32'h0);
        chk("abort_valid", 32'(valid), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        rx = 1'b1;
        exp_q.delete();
        win_lo     = 0;
        win_hi     = 0;
        model_data = 8'h00;
        repeat (3) @(posedge CLKIN);
        #2 RESET = 1'b0;
        repeat (3) wait_tick();
        chk("abort_no_pulse", 32'(valid_seen - v0), 32'd0);
        send_frame(8'h5A, 1'b1, -1);
        repeat (2) wait_tick();
        chk("after_reset_data", 32'(data), 32'h5A);

        v0 = valid_seen;
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        repeat (2) wait_tick();
        chk("b2b_valid_count", 32'(valid_seen - v0), 32'd2);
        chk("b2b_data", 32'(data), 32'hFF);

        fork
            send_frame(8'h96, 1'b1, -1);
            begin
                repeat (60) @(posedge CLKIN iff baud_tick);
                #3 tick_en = 1'b0;
                repeat (100) @(posedge CLKIN);
                tick_en = 1'b1;
            end
        join
        repeat (2) wait_tick();
        chk("hold_data", 32'(data), 32'h96);

        for (int k = 0; k < 6; k++) begin
            gap = $urandom_range(0, 3);
            repeat (gap) wait_tick();
            rb = 8'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            send_frame(rb, rs, -1);
        end
        repeat (3) wait_tick();
        chk("pending_events", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter OVERSAMPLE, default 16, is the number of baud_tick pulses per serial bit period; it SHALL be even and at least 4.
REQ-002 Parameter DATA_BITS, default 8, is the number of data bits per frame.
REQ-003 CLKIN  input  1  is the single clock; all state SHALL change on its rising edge.
REQ-004 RESET  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 baud_tick  input  1  is a single-cycle oversample strobe from the upstream baud generator.
REQ-006 rx  input  1  is the asynchronous serial line; it idles high.
REQ-007 data  output  DATA_BITS  is the last correctly framed byte.
REQ-008 valid  output  1  is a one-cycle pulse marking a new value on data.
REQ-009 frame_err  output  1  is a one-cycle pulse marking a stop bit sampled low.
REQ-010 busy  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (rx_s); all decisions SHALL use rx_s only.
REQ-012 All counters and sampling SHALL advance only on cycles where baud_tick=1; with baud_tick held at 0 all state SHALL hold.
REQ-013 FSM states SHALL be IDLE, START, DATA and STOP.
REQ-014 IDLE: on a tick with rx_s=0 -> START, tick_cnt=0; otherwise remain.
REQ-015 START: tick_cnt increments per tick; on the tick where tick_cnt reaches OVERSAMPLE/2-1, sample rx_s: 1 -> IDLE (glitch, no outputs); 0 -> DATA with tick_cnt=0, bit_cnt=0.
REQ-016 DATA: on the tick where tick_cnt reaches OVERSAMPLE-1, sample rx_s into the shift register LSB-first (shift right, insert at MSB), clear tick_cnt, increment bit_cnt; after sample DATA_BITS-1 -> STOP.
REQ-017 STOP: on the tick where tick_cnt reaches OVERSAMPLE-1, sample rx_s: 1 -> load data from the shift register and pulse valid; 0 -> pulse frame_err and leave data unchanged; both -> IDLE.
REQ-018 valid and frame_err SHALL be registered, asserted in the cycle after the stop-sampling tick, for exactly one CLKIN cycle, and never both high.
REQ-019 data SHALL hold its value until the next valid frame.
REQ-020 A frame beginning on the tick after the stop sample SHALL be accepted; there is no dead time.
REQ-021 tick_cnt SHALL be clog2(OVERSAMPLE) bits and bit_cnt clog2(DATA_BITS+1) bits, and neither SHALL wrap within a frame.

Reset
REQ-022 While RESET is high: state=IDLE, synchronizer flops=1, counters=0, shift register=0, data=0, valid=0, frame_err=0, busy=0.
REQ-023 RESET asserted mid-frame SHALL abort the frame with no valid or frame_err pulse; reception SHALL restart only at the next falling edge seen after release.

Structure
REQ-024 The FSM state encoding and the default OVERSAMPLE/DATA_BITS constants SHALL live in the shared uart package also used by the baud generator and the transmitter.
REQ-025 The 2-flop synchronizer SHALL be a separate sub-module, sync2, with the same reset; everything else stays in uart_rx.

Verification (OVERSAMPLE=16, baud_tick every 25th cycle from the baud generator)
REQ-026 Send 0xA5 with a good stop bit -> data=0xA5, valid high for exactly 1 cycle, frame_err=0, busy low after the stop sample.
REQ-027 Drive rx low for 4 ticks, then high -> FSM returns to IDLE, with no valid and no frame_err pulse.
REQ-028 Send 0x3C with the stop bit low, after a prior good 0x11 -> frame_err pulses once and data stays 0x11.
REQ-029 Assert RESET during bit 3 of a frame -> all outputs are 0 immediately, and no pulse appears from the aborted frame; a following 0x5A is received correctly.
REQ-030 Send 0x00 and 0xFF back-to-back with no idle gap -> two valid pulses with data 0x00 then 0xFF.
REQ-031 Hold baud_tick at 0 for 100 cycles mid-frame, then resume -> the frame completes with the correct byte.
